fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage of the multicycle core.
- Owns the fetch PC and issues one word read per cycle to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) that flushes all buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types and constants for the fetch stage
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef logic [XLEN-1:0] insn_t;

    localparam insn_t NOP = 32'h0000_0013;

    typedef struct packed {
        insn_t           word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {word, pc} entries with flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t      mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign head = mem[rd_ptr];

    // Flush wins over a same-cycle push so a killed word can never land.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, ROM issue and redirect kill for decode
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              insn_valid,
    output logic [31:0]       insn,
    output logic [31:0]       insn_pc,
    input  logic              insn_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fpc;
    logic [31:0]   infl_pc;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          transfer;
    logic          push;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    assign insn_valid = (count != '0) && !redirect_valid;
    assign insn       = head.word;
    assign insn_pc    = head.pc;
    assign transfer   = insn_valid && insn_ready;

    // Count the in-flight word as occupied so its response always has a slot.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(transfer);
    assign rom_en    = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign rom_addr  = fpc[ADDR_W+1:2];

    assign push      = inflight && !kill;
    assign push_data = '{word: rom_data, pc: infl_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            infl_pc  <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (redirect_valid) begin
            fpc      <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            kill     <= inflight;
        end else begin
            inflight <= rom_en;
            kill     <= 1'b0;
            if (rom_en) begin
                infl_pc <= fpc;
                fpc     <= fpc + 32'd4;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (transfer && !rst),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(7), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .insn_ready     (insn_ready)
    );

    // Synchronous ROM: word i holds 0x1000_0000 + i, one cycle latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'h1000_0000 + {25'd0, rom_addr};
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        int          chk;      // 0 none, 1 control only, 2 control and data
        logic        e_en;
        logic [6:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_insn;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 + i;
    endfunction

    task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input int chk, input logic en, input int addr, input logic v,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.chk = chk;
        t.e_en = en; t.e_addr = 7'(addr); t.e_valid = v; t.e_insn = ei; t.e_pc = ep;
        tbl.push_back(t);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int en_pulses;
    int waited;
    logic seen_bad;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b1;

        add(1,0,0,1, 0, 0,0,0,0,0);
        add(1,0,0,1, 2, 0,0,0,0,0);
        add(0,0,0,1, 1, 1,0,0,0,0);
        add(0,0,0,1, 1, 1,1,0,0,0);
        add(0,0,0,1, 2, 1,2,1,w(0),0);
        add(0,0,0,1, 2, 1,3,1,w(1),4);
        add(0,0,0,1, 2, 1,4,1,w(2),8);
        add(0,0,0,1, 2, 1,5,1,w(3),12);
        add(0,1,32'h40,1, 1, 0,0,0,0,0);
        add(0,0,0,1, 1, 1,16,0,0,0);
        add(0,0,0,1, 1, 1,17,0,0,0);
        add(0,0,0,1, 2, 1,18,1,w(16),32'h40);
        add(0,0,0,1, 2, 1,19,1,w(17),32'h44);
        add(0,1,32'h43,1, 1, 0,0,0,0,0);
        add(0,0,0,1, 1, 1,16,0,0,0);
        add(0,0,0,1, 1, 1,17,0,0,0);
        add(0,0,0,1, 2, 1,18,1,w(16),32'h40);
        add(0,0,0,1, 2, 1,19,1,w(17),32'h44);
        add(0,1,32'h1F8,1, 1, 0,0,0,0,0);
        add(0,0,0,1, 1, 1,126,0,0,0);
        add(0,0,0,1, 1, 1,127,0,0,0);
        add(0,0,0,1, 2, 1,0,1,w(126),32'h1F8);
        add(0,0,0,1, 2, 1,1,1,w(127),32'h1FC);
        add(0,0,0,1, 2, 1,2,1,w(0),32'h200);
        add(0,0,0,0, 2, 0,0,1,w(1),32'h204);
        add(0,0,0,0, 2, 0,0,1,w(1),32'h204);
        add(0,0,0,0, 2, 0,0,1,w(1),32'h204);
        add(0,0,0,1, 2, 1,3,1,w(1),32'h204);
        add(0,0,0,1, 2, 1,4,1,w(2),32'h208);
        add(0,0,0,1, 2, 1,5,1,w(3),32'h20C);
        add(0,0,0,0, 2, 0,0,1,w(4),32'h210);
        add(0,0,0,0, 2, 0,0,1,w(4),32'h210);
        add(1,0,0,1, 0, 0,0,0,0,0);
        add(0,0,0,1, 1, 1,0,0,0,0);
        add(0,0,0,1, 1, 1,1,0,0,0);
        add(0,0,0,1, 2, 1,2,1,w(0),0);
        add(0,0,0,1, 2, 1,3,1,w(1),4);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc; insn_ready = tbl[i].rdy;
            #2;
            if (tbl[i].chk >= 1) begin
                cmp($sformatf("v%0d rom_en", i), {31'd0, rom_en}, {31'd0, tbl[i].e_en});
                cmp($sformatf("v%0d insn_valid", i), {31'd0, insn_valid}, {31'd0, tbl[i].e_valid});
                if (tbl[i].e_en)
                    cmp($sformatf("v%0d rom_addr", i), {25'd0, rom_addr}, {25'd0, tbl[i].e_addr});
            end
            if (tbl[i].chk == 2) begin
                cmp($sformatf("v%0d insn", i), insn, tbl[i].e_insn);
                cmp($sformatf("v%0d insn_pc", i), insn_pc, tbl[i].e_pc);
            end
        end

        // Stall from reset: exactly two fetches fill the buffer, head holds.
        @(negedge clk); rst = 1'b1; redirect_valid = 1'b0; insn_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        en_pulses = 0;
        for (int c = 0; c < 6; c++) begin
            #2; if (rom_en) en_pulses++;
            @(negedge clk);
        end
        cmp("stall rom_en pulses", en_pulses, 2);
        cmp("stall valid", {31'd0, insn_valid}, 32'd1);
        cmp("stall insn", insn, w(0));
        cmp("stall pc", insn_pc, 32'h0);
        insn_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            cmp($sformatf("drain%0d valid", k), {31'd0, insn_valid}, 32'd1);
            cmp($sformatf("drain%0d pc", k), insn_pc, 32'(4 * k));
            cmp($sformatf("drain%0d insn", k), insn, w(k));
            @(negedge clk);
        end

        // Back-to-back redirects: only the second target may ever be delivered.
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk); redirect_pc = 32'h100;
        @(negedge clk); redirect_valid = 1'b0;
        waited = 1; seen_bad = 1'b0;
        #2;
        while (!insn_valid && waited < 10) begin
            @(negedge clk); #2; waited++;
        end
        cmp("b2b latency", waited, 3);
        cmp("b2b pc", insn_pc, 32'h100);
        cmp("b2b insn", insn, w(64));
        for (int k = 0; k < 4; k++) begin
            if (!insn_valid || insn_pc < 32'h100) seen_bad = 1'b1;
            @(negedge clk); #2;
        end
        cmp("b2b stream clean", {31'd0, seen_bad}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
